// File: rtl/mb_point_test_rx_if.sv
// Handshake/bus bundle between a calibration FSM (master) and the point-test receiver (slave).
interface mb_point_test_rx_if #(
  parameter int NUM_LANES = 16
);
  logic                 i_en;
  logic                 i_mainband_or_valtrain_test;
  logic                 i_pattern_valid;
  logic [NUM_LANES-1:0] i_rx_lane_bits;
  logic                 i_rx_valid_bit;
  logic [15:0]          o_rx_lanes_result;
  logic                 o_test_ack;
  logic                 o_timeout;
  logic                 o_busy;

  modport master (
    output i_en, i_mainband_or_valtrain_test, i_pattern_valid, i_rx_lane_bits, i_rx_valid_bit,
    input  o_rx_lanes_result, o_test_ack, o_timeout, o_busy
  );

  modport slave (
    input  i_en, i_mainband_or_valtrain_test, i_pattern_valid, i_rx_lane_bits, i_rx_valid_bit,
    output o_rx_lanes_result, o_test_ack, o_timeout, o_busy
  );
endinterface

// File: rtl/mb_point_test_rx.sv
// MBTRAIN receiver point test: compares received lane (or valid-lane) bits against a local
// expected pattern over NUM_ITER beats and reports a per-lane pass mask with an ack handshake.
module mb_point_test_rx #(
  parameter int          NUM_LANES  = 16,
  parameter int          NUM_ITER   = 4096,
  parameter int          ERR_W      = 12,
  parameter int          ERR_THRESH = 0,
  parameter int          TIMEOUT    = 8192,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  mb_point_test_rx_if.slave bus
);

  localparam int BEAT_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_ITER - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0]  THRESH    = ERR_W'(ERR_THRESH);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [2:0]        phase_q, phase_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [ERR_W-1:0]  err_q [NUM_LANES];
  logic [ERR_W-1:0]  err_d [NUM_LANES];
  logic [ERR_W-1:0]  err_upd [NUM_LANES];
  logic [15:0]       result_q, result_d;
  logic              ack_q, ack_d;
  logic              timeout_q, timeout_d;

  logic              exp_bit;
  logic              compare;
  logic [NUM_LANES-1:0] miss;
  logic [15:0]       pass_vec;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt, input logic inc);
    if (inc && (cnt != {ERR_W{1'b1}})) return cnt + ERR_W'(1);
    return cnt;
  endfunction

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right; bit 0 is the expected data bit.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  assign exp_bit = mode_q ? ~phase_q[2] : lfsr_q[0];
  assign compare = bus.i_en && bus.i_pattern_valid && ((state_q == S_WAIT) || (state_q == S_CMP));

  // In VALTRAIN mode only the valid lane is checked and it is accounted on lane 0.
  always_comb begin
    miss = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mode_q) begin
        if (i == 0) miss[i] = bus.i_rx_valid_bit ^ exp_bit;
      end else begin
        miss[i] = bus.i_rx_lane_bits[i] ^ exp_bit;
      end
    end
  end

  always_comb begin
    pass_vec = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      err_upd[i] = sat_inc(err_q[i], miss[i]);
      if (!mode_q || (i == 0)) pass_vec[i] = (err_upd[i] <= THRESH);
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lfsr_d     = lfsr_q;
    phase_d    = phase_q;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    result_d   = result_q;
    ack_d      = ack_q;
    timeout_d  = timeout_q;
    for (int i = 0; i < NUM_LANES; i++) err_d[i] = err_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.i_en) begin
          state_d    = S_WAIT;
          mode_d     = bus.i_mainband_or_valtrain_test;
          lfsr_d     = LFSR_SEED;
          phase_d    = '0;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
          for (int i = 0; i < NUM_LANES; i++) err_d[i] = '0;
        end
      end
      S_WAIT, S_CMP: begin
        if (!bus.i_en) begin
          state_d = S_IDLE;
        end else if (compare) begin
          lfsr_d     = lfsr_next(lfsr_q);
          phase_d    = phase_q + 3'd1;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          for (int i = 0; i < NUM_LANES; i++) err_d[i] = err_upd[i];
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = S_DONE;
            ack_d    = 1'b1;
            result_d = pass_vec;
          end else begin
            state_d = S_CMP;
          end
        end else if (state_q == S_WAIT) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q == LAST_TMO) begin
            state_d   = S_DONE;
            ack_d     = 1'b1;
            timeout_d = 1'b1;
            result_d  = '0;
          end
        end
      end
      default: begin
        if (!bus.i_en) begin
          state_d   = S_IDLE;
          ack_d     = 1'b0;
          timeout_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      phase_q    <= '0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      result_q   <= '0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) err_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lfsr_q     <= lfsr_d;
      phase_q    <= phase_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      result_q   <= result_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
      for (int i = 0; i < NUM_LANES; i++) err_q[i] <= err_d[i];
    end
  end

  assign bus.o_rx_lanes_result = result_q;
  assign bus.o_test_ack        = ack_q;
  assign bus.o_timeout         = timeout_q;
  assign bus.o_busy            = (state_q == S_WAIT) || (state_q == S_CMP);

endmodule

// File: tb/tb_mb_point_test_rx.sv
// Directed-sequence bench for mb_point_test_rx with randomized beats, stalls and faults.
module tb_mb_point_test_rx;
  localparam int NL  = 16;
  localparam int NI  = 4096;
  localparam int TMO = 8192;
  localparam int ERR_MAX = 4095;
  localparam int TH  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mb_point_test_rx_if #(.NUM_LANES(NL)) bus ();

  mb_point_test_rx #(
    .NUM_LANES(NL), .NUM_ITER(NI), .ERR_W(12), .ERR_THRESH(TH),
    .TIMEOUT(TMO), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nchk  = 0;
  int nfail = 0;
  bit exp_mb [NI];
  int err_m  [NL];
  logic [15:0] last_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference pattern straight from the polynomial: new bit15 = b0^b2^b3^b5 of the current word.
  function automatic void build_lfsr();
    int unsigned s, fb;
    s = 32'hACE1;
    for (int k = 0; k < NI; k++) begin
      exp_mb[k] = s[0];
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
  endfunction

  function automatic logic [15:0] model_result(input bit mode);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      if (!mode || i == 0) r[i] = (err_m[i] <= TH);
    return r;
  endfunction

  // fault: 0 clean, 1 directed faults, 2 sparse random flips. abort_at<0 runs to completion.
  task automatic run_test(input string tag, input bit mode, input int fault, input bit stalls,
                          input int abort_at);
    int nst;
    bit e, vb;
    logic [NL-1:0] bits;
    logic [31:0] m;
    for (int i = 0; i < NL; i++) err_m[i] = 0;
    bus.i_mainband_or_valtrain_test = mode;
    bus.i_pattern_valid = 1'b0;
    bus.i_en = 1'b1;
    step();
    check({tag, "_busy_start"}, bus.o_busy, 1);
    for (int k = 0; k < NI; k++) begin
      nst = (stalls && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, 3) : 0;
      for (int s = 0; s < nst; s++) begin
        bus.i_pattern_valid = 1'b0;
        bus.i_rx_lane_bits  = NL'($urandom);
        bus.i_rx_valid_bit  = 1'($urandom);
        step();
      end
      if (k == abort_at) begin
        bus.i_en = 1'b0;
        bus.i_pattern_valid = 1'b0;
        step();
        check({tag, "_abort_busy"}, bus.o_busy, 0);
        check({tag, "_abort_ack"}, bus.o_test_ack, 0);
        check({tag, "_abort_result"}, bus.o_rx_lanes_result, last_res);
        repeat (5) step();
        check({tag, "_abort_ack_later"}, bus.o_test_ack, 0);
        return;
      end
      e = mode ? ((k % 8) < 4) : exp_mb[k];
      if (mode) begin
        bits = NL'($urandom);
        vb   = e ^ ((fault == 1) && (k == 100 || k == 3000));
        if (vb != e && err_m[0] < ERR_MAX) err_m[0]++;
      end else begin
        bits = {NL{e}};
        vb   = 1'($urandom);
        if (fault == 1) begin
          if (k == 10) bits[3] = ~bits[3];
          bits[15] = ~bits[15];
        end else if (fault == 2) begin
          m = '1;
          repeat (12) m = m & $urandom;
          bits = bits ^ m[NL-1:0];
        end
        for (int i = 0; i < NL; i++)
          if (bits[i] != e && err_m[i] < ERR_MAX) err_m[i]++;
      end
      if (k == NI - 1) check({tag, "_ack_not_early"}, bus.o_test_ack, 0);
      bus.i_rx_lane_bits  = bits;
      bus.i_rx_valid_bit  = vb;
      bus.i_pattern_valid = 1'b1;
      step();
    end
    bus.i_pattern_valid = 1'b0;
    check({tag, "_ack"}, bus.o_test_ack, 1);
    check({tag, "_timeout"}, bus.o_timeout, 0);
    check({tag, "_busy_done"}, bus.o_busy, 0);
    check({tag, "_result"}, bus.o_rx_lanes_result, model_result(mode));
    last_res = model_result(mode);
  endtask

  task automatic release_en(input string tag);
    bus.i_en = 1'b0;
    step();
    check({tag, "_ack_drop"}, bus.o_test_ack, 0);
    check({tag, "_timeout_drop"}, bus.o_timeout, 0);
    step();
  endtask

  initial begin
    build_lfsr();
    last_res = '0;
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_mainband_or_valtrain_test = 1'b0;
    bus.i_pattern_valid = 1'b0;
    bus.i_rx_lane_bits = '0;
    bus.i_rx_valid_bit = 1'b0;
    repeat (3) step();
    check("rst_ack", bus.o_test_ack, 0);
    check("rst_timeout", bus.o_timeout, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_result", bus.o_rx_lanes_result, 0);
    rst = 1'b0;
    step();

    run_test("mb_clean_stall", 1'b0, 0, 1'b1, -1);
    check("mb_clean_const", bus.o_rx_lanes_result, 16'hFFFF);
    release_en("mb_clean_stall");

    // Reset in the middle of a compare
    bus.i_mainband_or_valtrain_test = 1'b0;
    bus.i_en = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      bus.i_rx_lane_bits = {NL{exp_mb[k]}};
      bus.i_pattern_valid = 1'b1;
      step();
    end
    check("midrst_busy_before", bus.o_busy, 1);
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_pattern_valid = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_ack", bus.o_test_ack, 0);
    check("midrst_timeout", bus.o_timeout, 0);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_result", bus.o_rx_lanes_result, 0);
    last_res = '0;
    step();
    run_test("mb_after_rst", 1'b0, 0, 1'b0, -1);
    release_en("mb_after_rst");

    run_test("mb_fault", 1'b0, 1, 1'b1, -1);
    check("mb_fault_const", bus.o_rx_lanes_result, 16'h7FF7);
    repeat (20) step();
    check("hold_ack", bus.o_test_ack, 1);
    check("hold_result", bus.o_rx_lanes_result, 16'h7FF7);
    release_en("hold");
    check("released_result_kept", bus.o_rx_lanes_result, 16'h7FF7);

    run_test("abort", 1'b0, 0, 1'b0, 2000);
    step();

    run_test("vt_err", 1'b1, 1, 1'b1, -1);
    check("vt_err_const", bus.o_rx_lanes_result, 16'h0000);
    release_en("vt_err");
    run_test("vt_clean", 1'b1, 0, 1'b0, -1);
    check("vt_clean_const", bus.o_rx_lanes_result, 16'h0001);
    release_en("vt_clean");

    run_test("mb_rand", 1'b0, 2, 1'b1, -1);
    release_en("mb_rand");

    // Timeout: WAIT_PAT lasts TMO cycles with no beat
    bus.i_mainband_or_valtrain_test = 1'b0;
    bus.i_pattern_valid = 1'b0;
    bus.i_en = 1'b1;
    step();
    repeat (TMO - 1) step();
    check("tmo_ack_not_early", bus.o_test_ack, 0);
    check("tmo_busy_wait", bus.o_busy, 1);
    step();
    check("tmo_ack", bus.o_test_ack, 1);
    check("tmo_flag", bus.o_timeout, 1);
    check("tmo_result", bus.o_rx_lanes_result, 0);
    check("tmo_busy", bus.o_busy, 0);
    release_en("tmo");
    check("tmo_idle_busy", bus.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
